// File: rtl/acc_uart_tx_if.sv
// Accumulator tap bus: core-side sample inputs and UART-side status outputs.
interface acc_uart_tx_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;

  logic [7:0]      acc_v;
  logic            cy;
  logic            tx;
  logic            busy;
  logic [CNTW-1:0] fifo_count;
  logic            overflow;

  modport master (
    output acc_v, cy,
    input  tx, busy, fifo_count, overflow
  );

  modport slave (
    input  acc_v, cy,
    output tx, busy, fifo_count, overflow
  );
endinterface

// File: rtl/acc_uart_tx.sv
// Queues each change of {cy, acc_v} and sends it as an 11-bit UART frame:
// start, acc bits 0..7, cy, stop.
module acc_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DEPTH        = 4
) (
  input logic          clk,
  input logic          rst,
  acc_uart_tx_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned BCW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned SW   = 9;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_last, w_sample;
  logic [SW-1:0]   r_shift, w_shift_nxt;
  logic [SW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CNTW-1:0] r_count;
  logic            r_overflow;
  logic            r_tx, w_tx_nxt;
  logic            r_busy, w_busy_nxt;
  logic [BCW-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]      r_bit_idx, w_bit_idx_nxt;
  logic            w_push_req, w_push, w_pop, w_full, w_empty, w_bit_end;

  assign w_sample   = {bus.cy, bus.acc_v};
  assign w_push_req = (w_sample != r_last);
  assign w_full     = (r_count == CNTW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_bit_end  = (r_bit_cnt == BCW'(CLKS_PER_BIT - 1));
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);

  // Next-state and registered-output logic for the frame serializer.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_pop         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = r_mem[r_rptr];
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_START;
          w_tx_nxt      = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end
      S_START: begin
        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = S_DATA;
          w_tx_nxt      = r_shift[0];
        end
      end
      S_DATA: begin
        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          if (r_bit_idx == 4'd8) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
            w_bit_idx_nxt = r_bit_idx + 4'd1;
          end
        end
      end
      S_STOP: begin
        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  // Change detector and FIFO bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_last <= w_sample;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_sample;
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_acc_uart_tx.sv
// Self-checking bench for acc_uart_tx: frame vectors, overflow/back-to-back and reset corners.
module tb_acc_uart_tx;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLEN  = 11 * CPB;

  typedef struct {
    logic [7:0]  acc;
    logic        cy;
    logic [10:0] frame;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   busy_run;
  int   last_run;
  int   mon_pos;
  int   frame_idx;
  bit   in_frame;
  logic [10:0] cap;
  logic [10:0] sb[$];
  vec_t vecs[6];

  acc_uart_tx_if #(.DEPTH(DEPTH)) bus();

  acc_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy || bus.fifo_count != 0) && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n < 2000), 32'd1);
    tick();
    tick();
  endtask

  // UART receiver: samples each bit mid-period and checks against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      else if (busy_run != 0) begin
        last_run = busy_run;
        busy_run = 0;
      end
      if (!in_frame && bus.tx == 1'b0) begin
        in_frame = 1'b1;
        mon_pos  = 0;
        cap      = '0;
      end
      if (in_frame) begin
        if (mon_pos % CPB == CPB / 2) cap[mon_pos / CPB] = bus.tx;
        mon_pos++;
        if (mon_pos == FLEN) begin
          in_frame = 1'b0;
          if (sb.size() == 0) begin
            chk($sformatf("frame_%0d_unexpected", frame_idx), 32'(cap), 32'h7ff);
          end else begin
            chk($sformatf("frame_%0d", frame_idx), 32'(cap), 32'(sb.pop_front()));
          end
          frame_idx++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    n_checks = 0; n_errors = 0; busy_run = 0; last_run = 0;
    mon_pos = 0; frame_idx = 0; in_frame = 1'b0; cap = '0;
    vecs[0] = '{8'hA5, 1'b1, 11'b1_1_10100101_0};
    vecs[1] = '{8'h3C, 1'b0, 11'b1_0_00111100_0};
    vecs[2] = '{8'h7F, 1'b0, 11'b1_0_01111111_0};
    vecs[3] = '{8'h7F, 1'b1, 11'b1_1_01111111_0};
    vecs[4] = '{8'hFF, 1'b0, 11'b1_0_11111111_0};
    vecs[5] = '{8'h00, 1'b1, 11'b1_1_00000000_0};

    rst = 1'b0; bus.acc_v = 8'h00; bus.cy = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Zero after reset is not a change: line must stay quiet.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_count != 0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    for (int i = 0; i < 6; i++) begin
      bus.acc_v = vecs[i].acc;
      bus.cy    = vecs[i].cy;
      sb.push_back(vecs[i].frame);
      last_run  = 0;
      tick();
      chk($sformatf("v%0d_queued", i), 32'(bus.fifo_count), 32'd1);
      tick();
      chk($sformatf("v%0d_start", i), {30'd0, bus.tx, bus.busy}, 32'b01);
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_busy_len", i), 32'(last_run), 32'(FLEN));
    end

    // Burst: 0x01 popped at once, 0x02..0x05 fill the FIFO, 0x06 dropped.
    last_run = 0;
    for (int v = 1; v <= 6; v++) begin
      bus.acc_v = 8'(v);
      bus.cy    = 1'b0;
      if (v <= 5) sb.push_back({1'b1, 1'b0, 8'(v), 1'b0});
      tick();
      if (v == 5) begin
        chk("burst_full_count", 32'(bus.fifo_count), 32'(DEPTH));
        chk("burst_no_ovf_yet", 32'(bus.overflow), 32'd0);
      end
    end
    chk("drop_count", 32'(bus.fifo_count), 32'(DEPTH));
    chk("drop_overflow", 32'(bus.overflow), 32'd1);
    // Edge 46 is the final STOP edge of frame 0x01: push and pop coincide while full.
    for (int i = 7; i <= 45; i++) tick();
    chk("pre_swap_count", 32'(bus.fifo_count), 32'(DEPTH));
    bus.acc_v = 8'h07;
    sb.push_back({1'b1, 1'b0, 8'h07, 1'b0});
    tick();
    chk("swap_count", 32'(bus.fifo_count), 32'(DEPTH));
    chk("swap_overflow", 32'(bus.overflow), 32'd1);
    wait_idle("burst");
    chk("burst_b2b_len", 32'(last_run), 32'(6 * FLEN));

    // Reset in the middle of the data bits of a 0x3C frame.
    bus.acc_v = 8'h3C;
    bus.cy    = 1'b0;
    sb.push_back({1'b1, 1'b0, 8'h3C, 1'b0});
    tick(); tick();
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_tx", 32'(bus.tx), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_count", 32'(bus.fifo_count), 32'd0);
    chk("arst_overflow", 32'(bus.overflow), 32'd0);
    sb.delete();
    tick();
    sb.push_back({1'b1, 1'b0, 8'h3C, 1'b0});
    last_run = 0;
    rst = 1'b0;
    tick();
    chk("rearm_queued", 32'(bus.fifo_count), 32'd1);
    wait_idle("rearm");
    chk("rearm_busy_len", 32'(last_run), 32'(FLEN));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("frames_seen", 32'(frame_idx), 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/acc_uart_tx.md
Name: acc_uart_tx

Overview:
Downstream consumer of the accumulator/carry outputs of the 8-bit accumulator CPU core. Samples {cy, acc_v} every clock and pushes each new value into a small FIFO on change. Serializes queued values on a single-wire UART line (start, 8 data bits LSB first, carry bit, stop), so program results are observable off-chip without probing the core.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit (>=2)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
acc_v  input  8  accumulator value from the core
cy  input  1  carry flag from the core
tx  output  1  serial line, idle high
busy  output  1  high while a frame is being transmitted
fifo_count  output  $clog2(DEPTH)+1  number of queued entries
overflow  output  1  sticky: a sample was dropped because FIFO was full

Behaviour:
- Reset (async, rst high): tx=1, busy=0, fifo_count=0, overflow=0, state IDLE, last_sample=9'h000, FIFO pointers cleared. Applies immediately, including mid-frame; any partial frame is abandoned with tx high.
- Change detect: each rising edge, if {cy,acc_v} != last_sample, request push of {cy,acc_v} and update last_sample. Identical consecutive values are never queued. The value 9'h000 right after reset is not queued.
- FIFO: DEPTH x 9 bits, circular, pointers wrap modulo DEPTH. Push when not full. Push when full and no pop that cycle -> sample dropped, overflow set to 1 until reset. Push and pop in the same cycle while full -> both succeed, count unchanged. Push and pop on empty cannot occur (pop requires non-empty). fifo_count updates on the same edge as the push/pop.
- Frame: 11 bits: start(0), acc bits 0..7, cy, stop(1). Each bit held exactly CLKS_PER_BIT cycles. Frame length 11*CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: tx=1, busy=0. On an edge with FIFO non-empty: pop head, load shifter, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 9 bits (8 data + cy) shifted LSB first, each CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On its final cycle: if FIFO non-empty, pop and go directly to START (no idle gap); else go IDLE.
- tx and busy are registered outputs. busy=1 in START/DATA/STOP.
- Latency: value changes before edge N -> pushed at edge N -> popped at edge N+1 if IDLE -> tx falls at edge N+1 (registered).
- Bit-period counter counts 0..CLKS_PER_BIT-1 and wraps. Bit index counter counts 0..8 in DATA.
- Inputs are sampled synchronously. No handshake back to the core. Data arriving faster than the line drains is dropped per overflow rule.

Test Plan:
- Reset then hold acc_v=0, cy=0 for 100 cycles -> no push, tx constant 1, busy=0, fifo_count=0.
- With CLKS_PER_BIT=4, step acc_v 0x00->0xA5, cy=1 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (LSB first), then cy=1, then stop 1. Total 44 cycles busy. busy falls after stop.
- Change acc_v every cycle through 0x01..0x06 while idle -> first value popped at once; 4 queued (fifo_count=4); 5th dropped with overflow=1. Frames for 0x01..0x05 transmitted back-to-back, no idle gap.
- FIFO full and a new value arrives on the cycle STOP ends with pop -> value accepted, fifo_count stays DEPTH, overflow unchanged.
- Assert rst mid-DATA of frame 0x3C -> tx=1, busy=0, fifo_count=0, overflow=0 immediately (before next clk edge). After release, the same acc_v value 0x3C is re-detected as a change and retransmitted in full.
- Hold acc_v=0x7F and toggle only cy 0->1 -> one frame queued with data 0x7F and 9th bit 1.
